vai_c2tx_arb: RTL and testbench
===============================

Name: vai_c2tx_arb

Overview:
Arbiter for the CCI-P c2 (MMIO read response) Tx channel in the VAI manager. It has two response sources: manager-local CSR read responses and responses returned from the sub-AFU mux. Each source gets its own small FIFO, and one response per cycle is forwarded to the single c2 output using round-robin order. The c2 channel has no backpressure, so responses are never silently overwritten. Drops only happen on FIFO overflow, and each overflow is recorded in a sticky status flag that feeds the manager status CSR.

Parameters:
DEPTH, 4, entries per source FIFO; power of two, ≥2
TID_W, 9, MMIO transaction ID width (t_ccip_tid)
DATA_W, 64, MMIO response data width
CNT_W, 16, width of the per-source forwarded-response counters

Ports:
clk  in  1  clock; all logic on rising edge
reset  in  1  asynchronous, active-high reset
loc_valid  in  1  local CSR response valid; one-cycle pulse per response
loc_tid  in  TID_W  local response tid
loc_data  in  DATA_W  local response data
sub_valid  in  1  sub-AFU mux response valid (mmioRdValid)
sub_tid  in  TID_W  sub-AFU response tid
sub_data  in  DATA_W  sub-AFU response data
clr_err  in  1  one-cycle pulse; clears the sticky overflow flags
out_valid  out  1  c2 mmioRdValid toward CCI-P
out_tid  out  TID_W  c2 hdr.tid
out_data  out  DATA_W  c2 data
loc_overflow  out  1  sticky: a local response was dropped
sub_overflow  out  1  sticky: a sub-AFU response was dropped
loc_cnt  out  CNT_W  local responses forwarded; wraps
sub_cnt  out  CNT_W  sub-AFU responses forwarded; wraps
loc_occ  out  clog2(DEPTH)+1  local FIFO occupancy
sub_occ  out  clog2(DEPTH)+1  sub-AFU FIFO occupancy

Behaviour:
- Reset (asynchronous, active-high) clears the following; all take effect immediately on assertion:
  - out_valid, out_tid, out_data = 0
  - both overflow flags = 0
  - both counters = 0
  - both occupancies = 0
  - FIFO pointers = 0
  - last_grant = SUB, so LOC wins the first contention
- Reset asserted mid-operation discards all queued responses.
- FIFO push: on an edge with src_valid=1, {tid,data} is written if occ<DEPTH, or if occ==DEPTH and the same FIFO pops on that edge.
- FIFO overflow: if occ==DEPTH, there is no pop and src_valid=1, the entry is dropped, the FIFO is unchanged and src_overflow is set to 1.
- Push and pop on the same edge: occ is unchanged; read/write pointers wrap modulo DEPTH.
- Arbitration, evaluated each edge on the pre-edge occupancies:
  - Neither FIFO non-empty: no grant.
  - Only one non-empty: grant it.
  - Both non-empty: grant the source that is not last_grant.
  - last_grant updates only on a grant.
- Output register:
  - On a grant, out_valid<=1 and out_tid/out_data<=FIFO head; the head pops and the granted counter increments (wraps at 2^CNT_W).
  - With no grant, out_valid<=0 and out_tid/out_data hold their previous values.
- Latency: a response presented on edge k to an empty FIFO, uncontended, appears with out_valid=1 in the cycle after edge k+1 (2 cycles).
- Ordering: responses from one source leave in arrival order. Under contention the two sources alternate, so neither waits more than one slot per queued response of the other.
- Throughput: at most one out_valid per cycle. Sustained combined input above 1/cycle fills the FIFOs and eventually overflows.
- Sticky flags:
  - Set on an overflow event and held until clr_err.
  - If clr_err and a new overflow occur on the same edge, set wins and the flag stays 1.
  - clr_err does not affect FIFOs or counters.
- No combinational path from inputs to outputs; all outputs are registered.

Test Plan:
- Single LOC response (tid=0x05, data=0xDEAD_BEEF) after reset -> out_valid=1 exactly one cycle, 2 cycles after input, tid=0x05, data=0xDEAD_BEEF; loc_cnt=1, sub_cnt=0.
- LOC and SUB pulse on the same edge (tids 0x01/0x02) from reset -> output tid 0x01 then 0x02 on consecutive cycles; out_valid low afterwards; both counters=1.
- SUB pulses on 8 consecutive edges while LOC pulses every edge for 4 edges, DEPTH=4 -> output strictly alternates LOC/SUB while both non-empty; sub_occ peaks at 4; no overflow on the push+pop-when-full edges; sub_overflow=1 only if a push hits full with no pop; all accepted SUB tids leave in order.
- Fill SUB FIFO to 4 with LOC continuously winning (block SUB grants by keeping LOC busy), then one more SUB pulse -> the 5th tid never appears at the output; sub_overflow=1; sub_occ stays 4.
- sub_overflow=1, then clr_err pulse -> flag 0 next cycle; clr_err coincident with a new overflow -> flag remains 1.
- Assert reset while both FIFOs hold 3 entries and out_valid=1 -> all outputs 0 immediately; no queued response emerges after release; counters=0.
- Counter wrap with CNT_W=4 -> after 17 forwarded LOC responses, loc_cnt=1.

Source files
------------

// File: rtl/vai_c2tx_arb.sv
// vai_c2tx_arb
// Arbiter for the CCI-P c2 (MMIO read response) Tx channel of the VAI manager.
// Two response sources are each buffered in a small FIFO:
//   - manager-local CSR read responses (loc_*)
//   - responses returned from the sub-AFU mux (sub_*)
// One response per cycle is forwarded to the c2 output in round-robin order.
// c2 has no backpressure, so a response is only lost when its FIFO is full
// and nothing pops on that edge; such a drop sets a sticky overflow flag.
//
// Ports:
//   clk, reset                   clock, asynchronous active-high reset
//   loc_valid/loc_tid/loc_data   local CSR response (one-cycle pulse)
//   sub_valid/sub_tid/sub_data   sub-AFU mux response
//   clr_err                      one-cycle pulse clearing the overflow flags
//   out_valid/out_tid/out_data   registered c2 response toward CCI-P
//   loc_overflow, sub_overflow   sticky drop flags
//   loc_cnt, sub_cnt             forwarded-response counters (wrapping)
//   loc_occ, sub_occ             FIFO occupancies
module vai_c2tx_arb #(
    parameter int DEPTH  = 4,
    parameter int TID_W  = 9,
    parameter int DATA_W = 64,
    parameter int CNT_W  = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       loc_valid,
    input  logic [TID_W-1:0]           loc_tid,
    input  logic [DATA_W-1:0]          loc_data,
    input  logic                       sub_valid,
    input  logic [TID_W-1:0]           sub_tid,
    input  logic [DATA_W-1:0]          sub_data,
    input  logic                       clr_err,
    output logic                       out_valid,
    output logic [TID_W-1:0]           out_tid,
    output logic [DATA_W-1:0]          out_data,
    output logic                       loc_overflow,
    output logic                       sub_overflow,
    output logic [CNT_W-1:0]           loc_cnt,
    output logic [CNT_W-1:0]           sub_cnt,
    output logic [$clog2(DEPTH):0]     loc_occ,
    output logic [$clog2(DEPTH):0]     sub_occ
);

    localparam int AW = $clog2(DEPTH);
    localparam int OW = AW + 1;
    localparam int EW = TID_W + DATA_W;

    typedef enum logic {SRC_LOC, SRC_SUB} src_e;

    logic [EW-1:0] loc_mem [DEPTH];
    logic [EW-1:0] sub_mem [DEPTH];
    logic [AW-1:0] loc_wr, loc_rd, sub_wr, sub_rd;

    src_e last_grant, last_grant_nxt;

    logic          loc_ne, sub_ne, loc_full, sub_full;
    logic          grant_loc, grant_sub;
    logic          loc_push, sub_push, loc_ovf, sub_ovf;
    logic [EW-1:0] head;

    // Arbitration and push/drop decisions, all on pre-edge occupancies.
    always_comb begin
        loc_ne    = (loc_occ != '0);
        sub_ne    = (sub_occ != '0);
        loc_full  = (loc_occ == OW'(DEPTH));
        sub_full  = (sub_occ == OW'(DEPTH));
        grant_loc = loc_ne && (!sub_ne || last_grant == SRC_SUB);
        grant_sub = sub_ne && (!loc_ne || last_grant == SRC_LOC);
        // A full FIFO still accepts a push when it pops on the same edge.
        loc_push  = loc_valid && (!loc_full || grant_loc);
        sub_push  = sub_valid && (!sub_full || grant_sub);
        loc_ovf   = loc_valid && loc_full && !grant_loc;
        sub_ovf   = sub_valid && sub_full && !grant_sub;
        head      = grant_loc ? loc_mem[loc_rd] : sub_mem[sub_rd];
    end

    always_comb begin
        last_grant_nxt = last_grant;
        if (grant_loc)
            last_grant_nxt = SRC_LOC;
        else if (grant_sub)
            last_grant_nxt = SRC_SUB;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            last_grant <= SRC_SUB;
        else
            last_grant <= last_grant_nxt;
    end

    // Storage is not reset; pointers and occupancy define what is valid.
    always_ff @(posedge clk) begin
        if (loc_push)
            loc_mem[loc_wr] <= {loc_tid, loc_data};
        if (sub_push)
            sub_mem[sub_wr] <= {sub_tid, sub_data};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            loc_wr  <= '0;
            loc_rd  <= '0;
            loc_occ <= '0;
            sub_wr  <= '0;
            sub_rd  <= '0;
            sub_occ <= '0;
        end else begin
            if (loc_push)
                loc_wr <= loc_wr + AW'(1);
            if (grant_loc)
                loc_rd <= loc_rd + AW'(1);
            loc_occ <= loc_occ + OW'(loc_push) - OW'(grant_loc);
            if (sub_push)
                sub_wr <= sub_wr + AW'(1);
            if (grant_sub)
                sub_rd <= sub_rd + AW'(1);
            sub_occ <= sub_occ + OW'(sub_push) - OW'(grant_sub);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_tid   <= '0;
            out_data  <= '0;
            loc_cnt   <= '0;
            sub_cnt   <= '0;
        end else begin
            out_valid <= grant_loc || grant_sub;
            if (grant_loc || grant_sub) begin
                out_tid  <= head[EW-1:DATA_W];
                out_data <= head[DATA_W-1:0];
            end
            if (grant_loc)
                loc_cnt <= loc_cnt + CNT_W'(1);
            if (grant_sub)
                sub_cnt <= sub_cnt + CNT_W'(1);
        end
    end

    // A new overflow on the same edge as clr_err keeps the flag set.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            loc_overflow <= 1'b0;
            sub_overflow <= 1'b0;
        end else begin
            if (loc_ovf)
                loc_overflow <= 1'b1;
            else if (clr_err)
                loc_overflow <= 1'b0;
            if (sub_ovf)
                sub_overflow <= 1'b1;
            else if (clr_err)
                sub_overflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_vai_c2tx_arb.sv
module tb_vai_c2tx_arb;

    localparam int DEPTH  = 4;
    localparam int TID_W  = 9;
    localparam int DATA_W = 64;
    localparam int CNT_W  = 4;
    localparam int OW     = $clog2(DEPTH) + 1;
    localparam int EW     = TID_W + DATA_W;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              loc_valid = 1'b0;
    logic [TID_W-1:0]  loc_tid = '0;
    logic [DATA_W-1:0] loc_data = '0;
    logic              sub_valid = 1'b0;
    logic [TID_W-1:0]  sub_tid = '0;
    logic [DATA_W-1:0] sub_data = '0;
    logic              clr_err = 1'b0;
    logic              out_valid;
    logic [TID_W-1:0]  out_tid;
    logic [DATA_W-1:0] out_data;
    logic              loc_overflow, sub_overflow;
    logic [CNT_W-1:0]  loc_cnt, sub_cnt;
    logic [OW-1:0]     loc_occ, sub_occ;

    vai_c2tx_arb #(.DEPTH(DEPTH), .TID_W(TID_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset),
        .loc_valid(loc_valid), .loc_tid(loc_tid), .loc_data(loc_data),
        .sub_valid(sub_valid), .sub_tid(sub_tid), .sub_data(sub_data),
        .clr_err(clr_err),
        .out_valid(out_valid), .out_tid(out_tid), .out_data(out_data),
        .loc_overflow(loc_overflow), .sub_overflow(sub_overflow),
        .loc_cnt(loc_cnt), .sub_cnt(sub_cnt),
        .loc_occ(loc_occ), .sub_occ(sub_occ)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp)
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        else
            n_pass++;
    endtask

    // Behavioural model: two queues and a round-robin pointer.
    logic [EW-1:0]     mq_loc[$];
    logic [EW-1:0]     mq_sub[$];
    bit                m_last_sub = 1'b1;
    logic              m_valid = 1'b0;
    logic [TID_W-1:0]  m_tid = '0;
    logic [DATA_W-1:0] m_data = '0;
    logic              m_lovf = 1'b0, m_sovf = 1'b0;
    int                m_lcnt = 0, m_scnt = 0;

    initial forever begin
        @(posedge clk or posedge reset);
        if (reset) begin
            mq_loc.delete();
            mq_sub.delete();
            m_last_sub = 1'b1;
            m_valid = 1'b0;
            m_tid = '0;
            m_data = '0;
            m_lovf = 1'b0;
            m_sovf = 1'b0;
            m_lcnt = 0;
            m_scnt = 0;
        end else begin
            int g;
            bit nl, ns;
            logic [EW-1:0] e;
            g = 0;
            if (mq_loc.size() > 0 && mq_sub.size() > 0)
                g = m_last_sub ? 1 : 2;
            else if (mq_loc.size() > 0)
                g = 1;
            else if (mq_sub.size() > 0)
                g = 2;
            m_valid = (g != 0);
            if (g == 1) begin
                e = mq_loc.pop_front();
                {m_tid, m_data} = e;
                m_lcnt = (m_lcnt + 1) % (1 << CNT_W);
                m_last_sub = 1'b0;
            end else if (g == 2) begin
                e = mq_sub.pop_front();
                {m_tid, m_data} = e;
                m_scnt = (m_scnt + 1) % (1 << CNT_W);
                m_last_sub = 1'b1;
            end
            nl = 1'b0;
            ns = 1'b0;
            if (loc_valid) begin
                if (mq_loc.size() < DEPTH) mq_loc.push_back({loc_tid, loc_data});
                else nl = 1'b1;
            end
            if (sub_valid) begin
                if (mq_sub.size() < DEPTH) mq_sub.push_back({sub_tid, sub_data});
                else ns = 1'b1;
            end
            m_lovf = nl ? 1'b1 : (clr_err ? 1'b0 : m_lovf);
            m_sovf = ns ? 1'b1 : (clr_err ? 1'b0 : m_sovf);
        end
    end

    // Per-cycle comparison against the model.
    initial forever begin
        @(negedge clk);
        if (!reset) begin
            chk("m_out_valid", 64'(out_valid), 64'(m_valid));
            chk("m_out_tid", 64'(out_tid), 64'(m_tid));
            chk("m_out_data", out_data, m_data);
            chk("m_loc_ovf", 64'(loc_overflow), 64'(m_lovf));
            chk("m_sub_ovf", 64'(sub_overflow), 64'(m_sovf));
            chk("m_loc_cnt", 64'(loc_cnt), 64'(m_lcnt));
            chk("m_sub_cnt", 64'(sub_cnt), 64'(m_scnt));
            chk("m_loc_occ", 64'(loc_occ), 64'(mq_loc.size()));
            chk("m_sub_occ", 64'(sub_occ), 64'(mq_sub.size()));
        end
    end

    task automatic drive(input logic lv, input logic [TID_W-1:0] lt, input logic [DATA_W-1:0] ld,
                         input logic sv, input logic [TID_W-1:0] st, input logic [DATA_W-1:0] sd,
                         input logic clr);
        loc_valid = lv; loc_tid = lt; loc_data = ld;
        sub_valid = sv; sub_tid = st; sub_data = sd;
        clr_err = clr;
        @(negedge clk);
    endtask

    task automatic idle();
        drive(1'b0, '0, '0, 1'b0, '0, '0, 1'b0);
    endtask

    task automatic do_reset();
        loc_valid = 1'b0; sub_valid = 1'b0; clr_err = 1'b0;
        #2 reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Drives the 8-edge contention pattern: LOC on edges 0..3, SUB on 0..7.
    task automatic contention(input logic clr_last);
        for (int i = 0; i < 8; i++) begin
            drive(i < 4, TID_W'(9'h080 + i), 64'(i), 1'b1, TID_W'(9'h100 + i), 64'(32'h1000 + i),
                  (i == 7) ? clr_last : 1'b0);
            if (i == 6) begin
                chk("full_pushpop_occ", 64'(sub_occ), 64'd4);
                chk("full_pushpop_noovf", 64'(sub_overflow), 64'd0);
            end
        end
    endtask

    initial begin
        int seen_drop;

        // Reset state
        @(negedge clk);
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_loc_cnt", 64'(loc_cnt), 64'd0);
        chk("rst_sub_occ", 64'(sub_occ), 64'd0);
        chk("rst_sub_ovf", 64'(sub_overflow), 64'd0);
        @(negedge clk);
        reset = 1'b0;

        // Single LOC response: visible two edges after presentation, one cycle wide.
        drive(1'b1, 9'h005, 64'hDEAD_BEEF, 1'b0, '0, '0, 1'b0);
        chk("t1_lat_not_yet", 64'(out_valid), 64'd0);
        chk("t1_occ", 64'(loc_occ), 64'd1);
        idle();
        chk("t1_valid", 64'(out_valid), 64'd1);
        chk("t1_tid", 64'(out_tid), 64'h5);
        chk("t1_data", out_data, 64'hDEAD_BEEF);
        chk("t1_loc_cnt", 64'(loc_cnt), 64'd1);
        chk("t1_sub_cnt", 64'(sub_cnt), 64'd0);
        idle();
        chk("t1_one_cycle", 64'(out_valid), 64'd0);
        chk("t1_hold_tid", 64'(out_tid), 64'h5);

        // Simultaneous pulses from reset: LOC first.
        do_reset();
        drive(1'b1, 9'h001, 64'h11, 1'b1, 9'h002, 64'h22, 1'b0);
        idle();
        chk("t2_first_tid", 64'(out_tid), 64'h1);
        chk("t2_first_valid", 64'(out_valid), 64'd1);
        idle();
        chk("t2_second_tid", 64'(out_tid), 64'h2);
        chk("t2_second_data", out_data, 64'h22);
        idle();
        chk("t2_valid_low", 64'(out_valid), 64'd0);
        chk("t2_loc_cnt", 64'(loc_cnt), 64'd1);
        chk("t2_sub_cnt", 64'(sub_cnt), 64'd1);

        // Contention: SUB fills, 8th SUB pulse hits full with no pop and is dropped.
        do_reset();
        contention(1'b0);
        chk("t3_sub_ovf", 64'(sub_overflow), 64'd1);
        chk("t3_sub_occ_full", 64'(sub_occ), 64'd4);
        chk("t3_loc_ovf", 64'(loc_overflow), 64'd0);
        seen_drop = 0;
        for (int i = 0; i < 6; i++) begin
            idle();
            if (out_valid && out_tid == 9'h107) seen_drop++;
        end
        chk("t4_dropped_absent", 64'(seen_drop), 64'd0);
        chk("t3_loc_cnt", 64'(loc_cnt), 64'd4);
        chk("t3_sub_cnt", 64'(sub_cnt), 64'd7);

        // Sticky flag: clear, then clear coincident with a new overflow.
        drive(1'b0, '0, '0, 1'b0, '0, '0, 1'b1);
        chk("t5_cleared", 64'(sub_overflow), 64'd0);
        chk("t5_clr_keeps_cnt", 64'(sub_cnt), 64'd7);
        contention(1'b1);
        chk("t5_set_wins", 64'(sub_overflow), 64'd1);
        for (int i = 0; i < 6; i++) idle();

        // Reset mid-operation with 3 queued per source and out_valid high.
        do_reset();
        for (int i = 0; i < 5; i++)
            drive(1'b1, TID_W'(9'h040 + i), 64'(i), 1'b1, TID_W'(9'h140 + i), 64'(i), 1'b0);
        chk("t6_loc_occ3", 64'(loc_occ), 64'd3);
        chk("t6_sub_occ3", 64'(sub_occ), 64'd3);
        chk("t6_valid_pre", 64'(out_valid), 64'd1);
        loc_valid = 1'b0; sub_valid = 1'b0;
        #2 reset = 1'b1;
        #1;
        chk("t6_async_valid", 64'(out_valid), 64'd0);
        chk("t6_async_tid", 64'(out_tid), 64'd0);
        chk("t6_async_data", out_data, 64'd0);
        chk("t6_async_loc_occ", 64'(loc_occ), 64'd0);
        chk("t6_async_sub_occ", 64'(sub_occ), 64'd0);
        chk("t6_async_loc_cnt", 64'(loc_cnt), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            idle();
            chk("t6_no_ghost", 64'(out_valid), 64'd0);
        end
        chk("t6_cnt_zero", 64'(loc_cnt) + 64'(sub_cnt), 64'd0);

        // Counter wrap with 4-bit counters.
        do_reset();
        for (int i = 0; i < 17; i++)
            drive(1'b1, TID_W'(i), 64'(i), 1'b0, '0, '0, 1'b0);
        idle();
        idle();
        chk("t7_wrap", 64'(loc_cnt), 64'd1);
        chk("t7_last_tid", 64'(out_tid), 64'd16);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
